// File: rtl/ps2_scancode_rx.sv
// -----------------------------------------------------------------------------
// ps2_scancode_rx
//   Host-side PS/2 keyboard receiver. Synchronises and glitch-filters the PS/2
//   clock, deframes 11-bit device-to-host frames (start, 8 data LSB-first, odd
//   parity, stop), and folds the set-2 prefixes E0 (extended) and F0 (break)
//   into flags so one qualified key event is issued per press/release.
//
// Ports
//   clk          in   system clock, also samples the PS/2 lines
//   rst_n        in   asynchronous active-low reset
//   keyboardCLK  in   PS/2 clock from keyboard (asynchronous)
//   keyboardData in   PS/2 data from keyboard (asynchronous)
//   raw_valid    out  1-cycle pulse per good byte (prefixes included)
//   raw_byte     out  last good byte, held
//   code_valid   out  1-cycle pulse per non-prefix key code
//   code         out  key code, held
//   code_ext     out  code was preceded by E0
//   code_break   out  code was preceded by F0
//   err_parity   out  1-cycle pulse on parity failure
//   err_frame    out  1-cycle pulse on bad start/stop bit or inter-edge timeout
//
// FSM states
//   state     | meaning
//   ST_IDLE   | waiting for a start bit strobe
//   ST_SHIFT  | collecting the 8 data bits
//   ST_PARITY | waiting for the parity bit
//   ST_STOP   | waiting for the stop bit, then evaluate the frame
// -----------------------------------------------------------------------------
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       keyboardCLK,
    input  logic       keyboardData,
    output logic       raw_valid,
    output logic [7:0] raw_byte,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       code_break,
    output logic       err_parity,
    output logic       err_frame
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Synchronisers; reset to the idle-high level of the PS/2 lines so that
    // reset release never looks like a falling edge.
    logic clk_s1, clk_s2, dat_s1, dat_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= keyboardCLK;
            clk_s2 <= clk_s1;
            dat_s1 <= keyboardData;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: the filtered clock follows the synced clock only after
    // FILTER_LEN consecutive cycles at the new level. A filtered fall raises a
    // one-cycle strobe together with the data bit captured on that cycle.
    logic          clk_filt;
    logic [FW-1:0] flt_cnt;
    logic          strobe;
    logic          strobe_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt   <= 1'b1;
            flt_cnt    <= '0;
            strobe     <= 1'b0;
            strobe_bit <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clk_s2 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_filt   <= clk_s2;
                flt_cnt    <= '0;
                strobe     <= ~clk_s2;
                strobe_bit <= dat_s2;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    // Frame FSM and output registers
    state_t        state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic          par_bit, par_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic          ext_pend, ext_n;
    logic          brk_pend, brk_n;
    logic          raw_valid_n, code_valid_n, err_parity_n, err_frame_n;
    logic [7:0]    raw_byte_n, code_n;
    logic          code_ext_n, code_break_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            raw_valid  <= 1'b0;
            raw_byte   <= '0;
            code_valid <= 1'b0;
            code       <= '0;
            code_ext   <= 1'b0;
            code_break <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bitcnt     <= bitcnt_n;
            par_bit    <= par_n;
            tmo_cnt    <= tmo_n;
            ext_pend   <= ext_n;
            brk_pend   <= brk_n;
            raw_valid  <= raw_valid_n;
            raw_byte   <= raw_byte_n;
            code_valid <= code_valid_n;
            code       <= code_n;
            code_ext   <= code_ext_n;
            code_break <= code_break_n;
            err_parity <= err_parity_n;
            err_frame  <= err_frame_n;
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bitcnt_n     = bitcnt;
        par_n        = par_bit;
        tmo_n        = tmo_cnt;
        ext_n        = ext_pend;
        brk_n        = brk_pend;
        raw_valid_n  = 1'b0;
        raw_byte_n   = raw_byte;
        code_valid_n = 1'b0;
        code_n       = code;
        code_ext_n   = code_ext;
        code_break_n = code_break;
        err_parity_n = 1'b0;
        err_frame_n  = 1'b0;

        if (strobe) begin
            // Every strobe restarts the inter-edge timeout down-counter.
            tmo_n = TMO_LOAD;
            case (state)
                ST_IDLE: begin
                    if (strobe_bit) begin
                        err_frame_n = 1'b1;
                    end else begin
                        state_n  = ST_SHIFT;
                        bitcnt_n = '0;
                    end
                end
                ST_SHIFT: begin
                    shreg_n  = {strobe_bit, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_n = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_n   = strobe_bit;
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (!strobe_bit) begin
                        err_frame_n = 1'b1;
                    end else if ((^{shreg, par_bit}) != 1'b1) begin
                        err_parity_n = 1'b1;
                    end else begin
                        raw_valid_n = 1'b1;
                        raw_byte_n  = shreg;
                        if (shreg == 8'hE0) begin
                            ext_n = 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk_n = 1'b1;
                        end else begin
                            code_valid_n = 1'b1;
                            code_n       = shreg;
                            code_ext_n   = ext_pend;
                            code_break_n = brk_pend;
                            ext_n        = 1'b0;
                            brk_n        = 1'b0;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (tmo_cnt == '0) begin
                err_frame_n = 1'b1;
                state_n     = ST_IDLE;
            end else begin
                tmo_n = tmo_cnt - TW'(1);
            end
        end

        if (err_frame_n || err_parity_n) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_scancode_rx
//   Drives PS/2 frames bit by bit (data changes mid-high, random bit period),
//   predicts the receiver's events from the protocol rules and queues them; a
//   monitor pops one expectation per observed output pulse and compares.
// -----------------------------------------------------------------------------
module tb_ps2_scancode_rx;

    localparam int FILTER_LEN = 8;
    localparam int TMO        = 400;

    localparam int EV_RAW  = 0;
    localparam int EV_CODE = 1;
    localparam int EV_PERR = 2;
    localparam int EV_FERR = 3;
    localparam int EV_BAD  = 4;

    typedef struct {
        int         kind;
        logic [7:0] b;      // raw_byte expected when the event appears
        logic       ext;
        logic       brk;
        int         c0;     // bench cycle of the keyboardCLK fall that ends it
        bit         tmo;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kclk = 1'b1;
    logic       kdat = 1'b1;
    logic       raw_valid, code_valid, code_ext, code_break, err_parity, err_frame;
    logic [7:0] raw_byte, code;

    ps2_scancode_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keyboardCLK (kclk),
        .keyboardData(kdat),
        .raw_valid   (raw_valid),
        .raw_byte    (raw_byte),
        .code_valid  (code_valid),
        .code        (code),
        .code_ext    (code_ext),
        .code_break  (code_break),
        .err_parity  (err_parity),
        .err_frame   (err_frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  ev_seen  = 0;
    int  last_lat = 0;
    ev_t sb[$];

    // Reference model state: pending prefix flags and last good byte
    bit         ext_p = 1'b0;
    bit         brk_p = 1'b0;
    logic [7:0] last_raw = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic ev_t model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ev_t e;
        e.ext = 1'b0;
        e.brk = 1'b0;
        e.c0  = 0;
        e.tmo = 1'b0;
        if (bad_stop || bad_par) begin
            e.kind = bad_stop ? EV_FERR : EV_PERR;
            ext_p = 1'b0;
            brk_p = 1'b0;
        end else begin
            last_raw = b;
            if (b == 8'hE0) begin
                e.kind = EV_RAW;
                ext_p = 1'b1;
            end else if (b == 8'hF0) begin
                e.kind = EV_RAW;
                brk_p = 1'b1;
            end else begin
                e.kind = EV_CODE;
                e.ext = ext_p;
                e.brk = brk_p;
                ext_p = 1'b0;
                brk_p = 1'b0;
            end
        end
        e.b = last_raw;
        return e;
    endfunction

    function automatic ev_t model_ferr(input bit tmo);
        ev_t e;
        e.kind = EV_FERR;
        e.b = last_raw;
        e.ext = 1'b0;
        e.brk = 1'b0;
        e.c0 = 0;
        e.tmo = tmo;
        ext_p = 1'b0;
        brk_p = 1'b0;
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data changes mid-high, then the clock falls for half a period.
    task automatic send_bit(input bit b, input int half, input bit has_ev, input ev_t ev);
        ev_t e;
        e = ev;
        wait_cyc(half / 2);
        kdat = b;
        wait_cyc(half - half / 2);
        kclk = 1'b0;
        if (has_ev) begin
            e.c0 = cyc;
            sb.push_back(e);
        end
        wait_cyc(half);
        kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
        ev_t e;
        logic par;
        e = model_frame(b, bad_par, bad_stop);
        par = ~(^b) ^ bad_par;
        send_bit(1'b0, half, 1'b0, e);
        for (int i = 0; i < 8; i++) send_bit(b[i], half, 1'b0, e);
        send_bit(par, half, 1'b0, e);
        send_bit(~bad_stop, half, 1'b1, e);
        kdat = 1'b1;
        wait_cyc(half);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            wait_cyc(1);
            t++;
        end
        check(name, sb.size(), 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n && (raw_valid || code_valid || err_parity || err_frame)) begin
            int  obs;
            int  lat;
            ev_t e;
            ev_seen++;
            if (err_frame && !err_parity && !raw_valid && !code_valid) obs = EV_FERR;
            else if (err_parity && !err_frame && !raw_valid && !code_valid) obs = EV_PERR;
            else if (raw_valid && code_valid && !err_parity && !err_frame) obs = EV_CODE;
            else if (raw_valid && !code_valid && !err_parity && !err_frame) obs = EV_RAW;
            else obs = EV_BAD;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", obs, cyc);
            end else begin
                e = sb.pop_front();
                check("event_kind", obs, e.kind);
                check("raw_byte", raw_byte, e.b);
                if (e.kind == EV_CODE) begin
                    check("code", code, e.b);
                    check("code_ext", code_ext, e.ext);
                    check("code_break", code_break, e.brk);
                end
                lat = cyc - e.c0;
                if (e.tmo) begin
                    check("timeout_delay", lat, last_lat + TMO);
                end else begin
                    check("latency_bound", (lat >= 1 && lat <= FILTER_LEN + 4), 1);
                    last_lat = lat;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ev_t e;
        int  half;
        int  seen0;
        int  r;
        logic [7:0] b;

        wait_cyc(4);
        check("reset_outputs",
              32'({raw_valid, raw_byte, code_valid, code, code_ext, code_break, err_parity, err_frame}), 0);
        rst_n = 1'b1;
        wait_cyc(10);

        // 1: plain make code
        send_frame(8'h1C, 1'b0, 1'b0, 20);
        // 2: extended, then extended break
        send_frame(8'hE0, 1'b0, 1'b0, 24);
        send_frame(8'h75, 1'b0, 1'b0, 24);
        send_frame(8'hE0, 1'b0, 1'b0, 18);
        send_frame(8'hF0, 1'b0, 1'b0, 18);
        send_frame(8'h75, 1'b0, 1'b0, 18);
        drain("drain_prefix");
        // 3: parity error, and a parity error clearing a pending break
        send_frame(8'h1C, 1'b1, 1'b0, 20);
        send_frame(8'hF0, 1'b0, 1'b0, 20);
        send_frame(8'h33, 1'b1, 1'b0, 20);
        send_frame(8'h1C, 1'b0, 1'b0, 20);
        // 4: bad stop bit, then a stray strobe with data high while idle
        send_frame(8'h1C, 1'b0, 1'b1, 20);
        e = model_ferr(1'b0);
        send_bit(1'b1, 20, 1'b1, e);
        wait_cyc(30);
        send_frame(8'h4B, 1'b0, 1'b0, 20);
        drain("drain_errors");

        // 5: partial frame, clock stalls high -> timeout
        send_frame(8'hE0, 1'b0, 1'b0, 20);
        b = 8'h29;
        send_bit(1'b0, 20, 1'b0, e);
        for (int i = 0; i < 4; i++) send_bit(b[i], 20, 1'b0, e);
        e = model_ferr(1'b1);
        send_bit(b[4], 20, 1'b1, e);
        kdat = 1'b1;
        wait_cyc(TMO + 60);
        check("timeout_seen", sb.size(), 0);
        send_frame(8'h29, 1'b0, 1'b0, 20);
        drain("drain_timeout");

        // 6: short glitches produce nothing
        seen0 = ev_seen;
        for (int i = 0; i < 6; i++) begin
            kclk = 1'b0;
            wait_cyc(3);
            kclk = 1'b1;
            wait_cyc(12);
        end
        wait_cyc(40);
        check("glitch_no_event", ev_seen, seen0);

        // Reset mid-frame discards the frame and a pending break
        send_frame(8'hF0, 1'b0, 1'b0, 20);
        b = 8'h1C;
        send_bit(1'b0, 20, 1'b0, e);
        for (int i = 0; i < 4; i++) send_bit(b[i], 20, 1'b0, e);
        wait_cyc(3);
        rst_n = 1'b0;
        ext_p = 1'b0;
        brk_p = 1'b0;
        last_raw = 8'h00;
        wait_cyc(3);
        check("midframe_reset_outputs",
              32'({raw_valid, raw_byte, code_valid, code, code_ext, code_break, err_parity, err_frame}), 0);
        check("midframe_reset_sb", sb.size(), 0);
        kclk = 1'b1;
        kdat = 1'b1;
        wait_cyc(10);
        rst_n = 1'b1;
        wait_cyc(20);
        send_frame(8'h1C, 1'b0, 1'b0, 20);
        drain("drain_reset");

        // Random traffic
        for (int n = 0; n < 25; n++) begin
            half = $urandom_range(60, 16);
            r = $urandom_range(11, 0);
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else b = 8'($urandom_range(255, 0));
            send_frame(b, ($urandom_range(7, 0) == 0), ($urandom_range(9, 0) == 0), half);
            wait_cyc($urandom_range(20, 0));
        end
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
